// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file write-back path
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    // R0 has a dedicated write port used for the mul/div high half
    localparam int R0_IDX = 0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MEM,
        SRC_MD
    } src_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard with RAW/WAW hazard detection
module wb_scoreboard #(
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_reg,
    input  logic                 rsv_r0,
    input  logic [ADDR_W-1:0]    chk_reg1,
    input  logic [ADDR_W-1:0]    chk_reg2,
    input  logic [1:0]           wr_en,
    input  logic [ADDR_W-1:0]    wr_reg,
    output logic                 hazard,
    output logic [2**ADDR_W-1:0] busy
);
    import regfile_pkg::*;

    localparam int NREG = 2**ADDR_W;

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Hazard is computed from the registered busy mask only, so the stall never depends on this cycle's write-back
    assign hazard = busy[chk_reg1] | busy[chk_reg2]
                  | (rsv_valid & busy[rsv_reg])
                  | (rsv_valid & rsv_r0 & busy[R0_IDX]);

    // Build the set and clear masks; a reservation is only accepted when decode is not stalled
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && !hazard) begin
            set_mask[rsv_reg] = 1'b1;
            if (rsv_r0) begin
                set_mask[R0_IDX] = 1'b1;
            end
        end
        if (wr_en[1]) begin
            clr_mask[wr_reg] = 1'b1;
        end
        if (wr_en[0]) begin
            clr_mask[R0_IDX] = 1'b1;
        end
    end

    // Busy register; applying the set after the clear makes a same-cycle set win
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter for ALU/load/muldiv with scoreboard (optional aging: WB_AGING_EN)
module regfile_wb_arbiter #(
    parameter int DATA_W       = regfile_pkg::DATA_W,
    parameter int ADDR_W       = regfile_pkg::ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 md_valid,
    output logic                 md_ready,
    input  logic [ADDR_W-1:0]    md_reg,
    input  logic [DATA_W-1:0]    md_lo,
    input  logic [DATA_W-1:0]    md_hi,
    input  logic                 rsv_valid,
    input  logic [ADDR_W-1:0]    rsv_reg,
    input  logic                 rsv_r0,
    input  logic [ADDR_W-1:0]    chk_reg1,
    input  logic [ADDR_W-1:0]    chk_reg2,
    output logic                 hazard,
    output logic [2**ADDR_W-1:0] busy,
    output logic [1:0]           reg_write,
    output logic [ADDR_W-1:0]    write_reg,
    output logic [DATA_W-1:0]    write_data,
    output logic [DATA_W-1:0]    r0
);
    import regfile_pkg::*;

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    src_t grant;

`ifdef WB_AGING_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] alu_wait;
    logic [CNT_W-1:0] mem_wait;
    logic             alu_promoted;
    logic             mem_promoted;

    assign alu_promoted = alu_valid && (alu_wait == LIMIT);
    assign mem_promoted = mem_valid && (mem_wait == LIMIT);

    // Wait counters saturate at the limit and restart whenever the requester is served or idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_wait <= '0;
            mem_wait <= '0;
        end else begin
            if (!alu_valid || alu_ready) begin
                alu_wait <= '0;
            end else if (alu_wait != LIMIT) begin
                alu_wait <= alu_wait + 1'b1;
            end
            if (!mem_valid || mem_ready) begin
                mem_wait <= '0;
            end else if (mem_wait != LIMIT) begin
                mem_wait <= mem_wait + 1'b1;
            end
        end
    end
`endif

    // Single grant per cycle: md > mem > alu, with starved requesters jumping the queue when aging is built in
    always_comb begin
        grant = SRC_NONE;
        if (md_valid) begin
            grant = SRC_MD;
        end else if (mem_valid) begin
            grant = SRC_MEM;
        end else if (alu_valid) begin
            grant = SRC_ALU;
        end
`ifdef WB_AGING_EN
        if (alu_promoted) begin
            grant = SRC_ALU;
        end
        if (mem_promoted) begin
            grant = SRC_MEM;
        end
`endif
    end

    assign md_ready  = (grant == SRC_MD);
    assign mem_ready = (grant == SRC_MEM);
    assign alu_ready = (grant == SRC_ALU);

    // Register the granted payload; an md write to R0 goes only through the general port to avoid a double write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write  <= 2'b00;
            write_reg  <= '0;
            write_data <= '0;
            r0         <= '0;
        end else begin
            case (grant)
                SRC_MD: begin
                    reg_write  <= {1'b1, (md_reg != ADDR_W'(R0_IDX))};
                    write_reg  <= md_reg;
                    write_data <= md_lo;
                    r0         <= md_hi;
                end
                SRC_MEM: begin
                    reg_write  <= 2'b10;
                    write_reg  <= mem_reg;
                    write_data <= mem_data;
                end
                SRC_ALU: begin
                    reg_write  <= 2'b10;
                    write_reg  <= alu_reg;
                    write_data <= alu_data;
                end
                default: begin
                    reg_write  <= 2'b00;
                end
            endcase
        end
    end

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .rsv_r0    (rsv_r0),
        .chk_reg1  (chk_reg1),
        .chk_reg2  (chk_reg2),
        .wr_en     (reg_write),
        .wr_reg    (write_reg),
        .hazard    (hazard),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter (aging checks follow WB_AGING_EN)
module tb_regfile_wb_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

`ifdef WB_AGING_EN
    localparam int AGE_CYCLE = 5;
`else
    localparam int AGE_CYCLE = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_reg = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_reg = '0;
    logic [DW-1:0] mem_data = '0;
    logic          md_valid = 1'b0;
    logic          md_ready;
    logic [AW-1:0] md_reg = '0;
    logic [DW-1:0] md_lo = '0;
    logic [DW-1:0] md_hi = '0;
    logic          rsv_valid = 1'b0;
    logic [AW-1:0] rsv_reg = '0;
    logic          rsv_r0 = 1'b0;
    logic [AW-1:0] chk_reg1 = '0;
    logic [AW-1:0] chk_reg2 = '0;
    logic          hazard;
    logic [15:0]   busy;
    logic [1:0]    reg_write;
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic [DW-1:0] r0;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_reg     (md_reg),
        .md_lo      (md_lo),
        .md_hi      (md_hi),
        .rsv_valid  (rsv_valid),
        .rsv_reg    (rsv_reg),
        .rsv_r0     (rsv_r0),
        .chk_reg1   (chk_reg1),
        .chk_reg2   (chk_reg2),
        .hazard     (hazard),
        .busy       (busy),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .r0         (r0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_write", 32'(reg_write), 32'h0);
        check("rst_write_reg", 32'(write_reg), 32'h0);
        check("rst_write_data", 32'(write_data), 32'h0);
        check("rst_r0", 32'(r0), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hazard", 32'(hazard), 32'h0);
        reset = 1'b1;

        // single alu write-back
        alu_valid = 1'b1; alu_reg = 4'd5; alu_data = 16'h1234;
        #1;
        check("alu_ready", 32'(alu_ready), 32'h1);
        check("alu_only_mem_ready", 32'(mem_ready), 32'h0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("alu_reg_write", 32'(reg_write), 32'h2);
        check("alu_write_reg", 32'(write_reg), 32'h5);
        check("alu_write_data", 32'(write_data), 32'h1234);
        tick();
        check("idle_reg_write", 32'(reg_write), 32'h0);
        check("idle_hold_data", 32'(write_data), 32'h1234);

        // three-way contention
        md_valid = 1'b1;  md_reg = 4'd3;  md_lo = 16'h00FF; md_hi = 16'hFF00;
        mem_valid = 1'b1; mem_reg = 4'd6; mem_data = 16'h0666;
        alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 16'h0999;
        #1;
        check("pri_md_ready", 32'({md_ready, mem_ready, alu_ready}), 32'h4);
        tick();
        md_valid = 1'b0;
        #1;
        check("md_reg_write", 32'(reg_write), 32'h3);
        check("md_write_reg", 32'(write_reg), 32'h3);
        check("md_write_data", 32'(write_data), 32'h00FF);
        check("md_r0", 32'(r0), 32'hFF00);
        check("pri_mem_ready", 32'({md_ready, mem_ready, alu_ready}), 32'h2);
        tick();
        mem_valid = 1'b0;
        #1;
        check("mem_reg_write", 32'(reg_write), 32'h2);
        check("mem_write_reg", 32'(write_reg), 32'h6);
        check("mem_write_data", 32'(write_data), 32'h0666);
        check("mem_r0_hold", 32'(r0), 32'hFF00);
        check("pri_alu_ready", 32'({md_ready, mem_ready, alu_ready}), 32'h1);
        tick();
        alu_valid = 1'b0;
        #1;
        check("alu2_write_reg", 32'(write_reg), 32'h9);
        check("alu2_write_data", 32'(write_data), 32'h0999);
        tick();
        check("unbusy_writes_busy", 32'(busy), 32'h0);

        // md targeting R0 uses only the general port
        md_valid = 1'b1; md_reg = 4'd0; md_lo = 16'hAAAA; md_hi = 16'h5555;
        tick();
        md_valid = 1'b0;
        #1;
        check("md_r0_reg_write", 32'(reg_write), 32'h2);
        check("md_r0_write_reg", 32'(write_reg), 32'h0);
        check("md_r0_write_data", 32'(write_data), 32'hAAAA);

        // reserve r7, stall on it until the alu write of r7 has cleared it
        rsv_valid = 1'b1; rsv_reg = 4'd7; chk_reg1 = 4'd1; chk_reg2 = 4'd1;
        #1;
        check("rsv_no_hazard", 32'(hazard), 32'h0);
        tick();
        rsv_valid = 1'b0; chk_reg1 = 4'd7;
        #1;
        check("rsv_busy7", 32'(busy), 32'h0080);
        check("raw_hazard", 32'(hazard), 32'h1);
        alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'h0777;
        tick();
        alu_valid = 1'b0;
        #1;
        check("wb7_reg_write", 32'(reg_write), 32'h2);
        check("wb7_hazard_still", 32'(hazard), 32'h1);
        tick();
        check("wb7_hazard_clear", 32'(hazard), 32'h0);
        check("wb7_busy_clear", 32'(busy), 32'h0);

        // same-cycle reserve and write-back of r2: set wins
        chk_reg1 = 4'd0; chk_reg2 = 4'd0;
        alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 16'h0222;
        tick();
        alu_valid = 1'b0;
        rsv_valid = 1'b1; rsv_reg = 4'd2;
        #1;
        check("setclr_write_reg", 32'(write_reg), 32'h2);
        tick();
        rsv_valid = 1'b0;
        #1;
        check("setclr_busy2", 32'(busy), 32'h0004);
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        check("clr2_busy", 32'(busy), 32'h0);

        // reserve r4 with R0, duplicate reservation stalls, md write clears both
        rsv_valid = 1'b1; rsv_reg = 4'd4; rsv_r0 = 1'b1;
        tick();
        #1;
        check("rsv_r0_busy", 32'(busy), 32'h0011);
        check("waw_hazard", 32'(hazard), 32'h1);
        rsv_valid = 1'b0; rsv_r0 = 1'b0;
        md_valid = 1'b1; md_reg = 4'd4; md_lo = 16'h0044; md_hi = 16'h4400;
        tick();
        md_valid = 1'b0;
        #1;
        check("md4_reg_write", 32'(reg_write), 32'h3);
        check("md4_r0", 32'(r0), 32'h4400);
        check("stall_kept_busy", 32'(busy), 32'h0011);
        tick();
        check("md4_busy_clear", 32'(busy), 32'h0);

        // aging: alu waits behind a continuous md stream
        md_valid = 1'b1; md_reg = 4'd8; md_lo = 16'h0088; md_hi = 16'h8800;
        alu_valid = 1'b1; alu_reg = 4'd10; alu_data = 16'h0AAA;
        for (int i = 1; i <= 6; i++) begin
            #1;
            check($sformatf("age_alu_ready_%0d", i), 32'(alu_ready), 32'(i == AGE_CYCLE));
            tick();
            if (i == AGE_CYCLE) alu_valid = 1'b0;
        end
        md_valid = 1'b0; alu_valid = 1'b0;
        tick();
        tick();

        // asynchronous reset right after a registered grant
        rsv_valid = 1'b1; rsv_reg = 4'd12;
        tick();
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_reg = 4'd11; alu_data = 16'hBEEF;
        tick();
        alu_valid = 1'b0;
        #1;
        check("pre_rst_reg_write", 32'(reg_write), 32'h2);
        check("pre_rst_busy", 32'(busy), 32'h1000);
        reset = 1'b0;
        #1;
        check("async_rst_reg_write", 32'(reg_write), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_data", 32'(write_data), 32'h0);
        tick();
        check("held_rst_reg_write", 32'(reg_write), 32'h0);
        reset = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 16x16 register file.
- Shares the file's single general write port and its dedicated R0 port between three producers: ALU, memory load, and multiply/divide.
- Mul/div writes its low result to Rd and its high result or remainder to R0 in the same cycle.
- Tracks pending destination registers so decode can stall on RAW/WAW hazards. Sits between execute/memory stages and the register file.

Parameters:
DATA_W, 16, register data width
ADDR_W, 4, register address width (2**ADDR_W registers)
STARVE_LIMIT, 4, wait cycles before a requester is promoted (optional feature only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU write-back request
alu_ready  out  1  ALU request accepted this cycle
alu_reg  in  ADDR_W  ALU destination
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load write-back request
mem_ready  out  1  load request accepted
mem_reg  in  ADDR_W  load destination
mem_data  in  DATA_W  load data
md_valid  in  1  mul/div write-back request
md_ready  out  1  mul/div request accepted
md_reg  in  ADDR_W  mul/div destination for low result
md_lo  in  DATA_W  product low / quotient
md_hi  in  DATA_W  product high / remainder, goes to R0
rsv_valid  in  1  decode reserves a destination
rsv_reg  in  ADDR_W  reserved destination
rsv_r0  in  1  also reserve R0 (mul/div issue)
chk_reg1  in  ADDR_W  decode source operand 1
chk_reg2  in  ADDR_W  decode source operand 2
hazard  out  1  decode must stall
busy  out  2**ADDR_W  pending-write mask
reg_write  out  2  [1] general write enable, [0] R0 write enable
write_reg  out  ADDR_W  to register file
write_data  out  DATA_W  to register file
r0  out  DATA_W  R0 write data to register file

Behaviour:
- Reset (reset=0, asynchronous): reg_write=2'b00, write_reg=0, write_data=0, r0=0, busy=0, all wait counters=0.
- Handshake and grant:
  - A requester holds valid and its payload stable until ready is high.
  - *_ready is combinational and is the grant.
  - At most one grant per cycle.
  - Fixed priority: md > mem > alu.
- Registered outputs, latency 1:
  - In the cycle after a grant, reg_write[1]=1 for exactly one cycle, with write_reg and write_data from the granted payload.
  - For an md grant, reg_write[0]=1 and r0=md_hi in the same cycle.
  - With no grant, reg_write=00. write_reg, write_data and r0 hold their last values.
- md with md_reg=0: both ports target R0. reg_write[0] is suppressed, so only md_lo is written to R0 via the general port. This avoids a double write.
- alu or mem with destination 0: written through the general port; reg_write[0]=0.
- Scoreboard:
  - Set: on rsv_valid and !hazard, busy[rsv_reg] is set next cycle. rsv_r0 also sets busy[0].
  - Clear: the cycle reg_write[1] is high clears busy[write_reg]; reg_write[0] clears busy[0].
  - Same-cycle set and clear of one bit: set wins.
- hazard (combinational from registered busy): busy[chk_reg1] | busy[chk_reg2] | (rsv_valid & busy[rsv_reg]) | (rsv_valid & rsv_r0 & busy[0]).
  - Because hazard covers the destination, a second reservation of a pending register cannot occur.
- A write-back to a register not marked busy is legal. The data is written and busy is unaffected.
- reset asserted mid-transfer: any pending registered write is discarded (reg_write forced to 00) and busy is cleared.

Optional Feature:
- Macro: WB_AGING_EN.
- Defined:
  - Each of mem and alu has a saturating wait counter (width clog2(STARVE_LIMIT+1)).
  - The counter increments each cycle its valid is high and it is not granted, and clears on grant or when valid is low.
  - A requester whose counter equals STARVE_LIMIT outranks md.
  - If both mem and alu are promoted, mem wins.
- Not defined: strict fixed priority; no counters synthesized.

Decomposition:
- Package regfile_pkg:
  - DATA_W and ADDR_W constants.
  - Enum src_t {SRC_NONE, SRC_ALU, SRC_MEM, SRC_MD}.
  - R0 index constant.
- Sub-module wb_scoreboard holds the busy register, set/clear logic and hazard compare. The arbiter top holds grant selection, aging counters and output registers.

Test Plan:
- Reset, then alu_valid with alu_reg=5 and alu_data=16'h1234 -> alu_ready=1 that cycle; next cycle reg_write=10, write_reg=5, write_data=16'h1234; following cycle reg_write=00.
- alu, mem and md all valid (md_reg=3, md_lo=16'h00FF, md_hi=16'hFF00) -> md granted first with reg_write=11, write_reg=3, r0=16'hFF00; then mem, then alu on successive cycles.
- md_reg=0, md_lo=16'hAAAA -> reg_write=10, write_reg=0, write_data=16'hAAAA; R0 port not enabled.
- rsv_valid with rsv_reg=7, then chk_reg1=7 -> hazard=1 until the cycle after the alu write of reg 7 (busy[7] clears with the write). Same-cycle reserve of reg 2 while reg 2 is written back -> busy[2] remains 1.
- With WB_AGING_EN and STARVE_LIMIT=4, md_valid held high and alu_valid high -> alu granted on its 5th waiting cycle. Without the macro, alu is never granted while md_valid stays high.
- reset pulsed low the cycle after a grant -> reg_write stays 00 and busy=0 immediately (asynchronous).
